// File: rtl/vedic4_mac_if.sv
// Handshake bundle for vedic4_mac: operand-pair input stream and result output stream.
interface vedic4_mac_if #(
    parameter int ACC_W = 12
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_a;
    logic [3:0]       in_b;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_sum;
    logic             out_ovf;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_sum, out_ovf
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_sum, out_ovf
    );
endinterface

// File: rtl/vedic4_mac.sv
// vedic4_mac: sums N_TERMS products of a registered 4x4 Vedic multiplier into one result.
// Define VEDIC4_MAC_SAT_EN to clamp the accumulator on overflow instead of wrapping.

module Vedic2x2 (
    input  logic [1:0] a_i,
    input  logic [1:0] b_i,
    output logic [3:0] p_o
);
    logic crossHi;
    logic crossLo;
    logic carry1;

    assign crossHi = a_i[1] & b_i[0];
    assign crossLo = a_i[0] & b_i[1];
    assign carry1  = crossHi & crossLo;
    assign p_o[0]  = a_i[0] & b_i[0];
    assign p_o[1]  = crossHi ^ crossLo;
    assign p_o[2]  = (a_i[1] & b_i[1]) ^ carry1;
    assign p_o[3]  = (a_i[1] & b_i[1]) & carry1;
endmodule

module vedic4 (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    output logic [7:0] p_o
);
    logic [3:0] qLL;
    logic [3:0] qHL;
    logic [3:0] qLH;
    logic [3:0] qHH;
    logic [5:0] midSum;
    logic [3:0] highSum;

    Vedic2x2 uLL (.a_i(a_i[1:0]), .b_i(b_i[1:0]), .p_o(qLL));
    Vedic2x2 uHL (.a_i(a_i[3:2]), .b_i(b_i[1:0]), .p_o(qHL));
    Vedic2x2 uLH (.a_i(a_i[1:0]), .b_i(b_i[3:2]), .p_o(qLH));
    Vedic2x2 uHH (.a_i(a_i[3:2]), .b_i(b_i[3:2]), .p_o(qHH));

    // Cross terms plus the upper half of the low partial product form bits [3:2] and a carry.
    assign midSum  = 6'(qHL) + 6'(qLH) + 6'(qLL[3:2]);
    assign highSum = qHH + midSum[5:2];
    assign p_o     = {highSum, midSum[1:0], qLL[1:0]};
endmodule

module vedic4_mac #(
    parameter int N_TERMS = 4,
    parameter int ACC_W   = 12
) (
    input  logic         clk,
    input  logic         rst,
    vedic4_mac_if.slave  bus
);
    typedef enum logic [1:0] {
        ACC,
        DRAIN,
        HOLD
    } state_e;

    localparam logic [7:0] LAST_TERM = 8'(N_TERMS - 1);

    state_e           state_q, state_d;
    logic [7:0]       termCnt_q, termCnt_d;
    logic [3:0]       aR_q, aR_d;
    logic [3:0]       bR_q, bR_d;
    logic             v1_q, v1_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic [7:0]       prod;
    logic [ACC_W:0]   sumWide;
    logic             accept;

    vedic4 uMul (.a_i(aR_q), .b_i(bR_q), .p_o(prod));

    assign bus.in_ready  = (state_q == ACC) && !rst;
    assign bus.out_valid = (state_q == HOLD);
    assign bus.out_sum   = acc_q;
    assign bus.out_ovf   = ovf_q;

    assign accept  = bus.in_valid && bus.in_ready;
    assign sumWide = {1'b0, acc_q} + (ACC_W + 1)'(prod);

    always_comb begin
        state_d   = state_q;
        termCnt_d = termCnt_q;
        aR_d      = aR_q;
        bR_d      = bR_q;
        v1_d      = accept;
        acc_d     = acc_q;
        ovf_d     = ovf_q;

        if (accept) begin
            aR_d      = bus.in_a;
            bR_d      = bus.in_b;
            termCnt_d = termCnt_q + 8'd1;
        end

        // The bit above the accumulator width is the carry out; it makes ovf sticky for the group.
        if (v1_q) begin
            if (sumWide[ACC_W]) begin
                ovf_d = 1'b1;
            end
`ifdef VEDIC4_MAC_SAT_EN
            acc_d = sumWide[ACC_W] ? '1 : sumWide[ACC_W-1:0];
`else
            acc_d = sumWide[ACC_W-1:0];
`endif
        end

        unique case (state_q)
            ACC: begin
                if (accept && (termCnt_q == LAST_TERM)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                state_d = HOLD;
            end
            HOLD: begin
                if (bus.out_ready) begin
                    state_d   = ACC;
                    acc_d     = '0;
                    ovf_d     = 1'b0;
                    termCnt_d = '0;
                    v1_d      = 1'b0;
                end
            end
            default: begin
                state_d = ACC;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ACC;
            termCnt_q <= '0;
            aR_q      <= '0;
            bR_q      <= '0;
            v1_q      <= 1'b0;
            acc_q     <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            termCnt_q <= termCnt_d;
            aR_q      <= aR_d;
            bR_q      <= bR_d;
            v1_q      <= v1_d;
            acc_q     <= acc_d;
            ovf_q     <= ovf_d;
        end
    end
endmodule

// File: tb/tb_vedic4_mac.sv
// Testbench for vedic4_mac: three parameterisations driven through a shared stimulus path,
// results scored against a queue of hand-derived expected sums.
module tb_vedic4_mac;
    typedef struct {
        int          sel;
        int          nTerms;
        logic [15:0] aVec;
        logic [15:0] bVec;
        int          gap;
        int          hold;
        int          expSum;
        logic        expOvf;
    } group_t;

    typedef struct {
        int   sum;
        logic ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        tbValid;
    logic [3:0]  inA;
    logic [3:0]  inB;
    logic        outReady;
    int          sel;
    logic        tbReady;
    logic        tbOutValid;
    logic [11:0] tbSum;
    logic        tbOvf;

    int   compared   = 0;
    int   mismatched = 0;
    exp_t expQ[$];

    vedic4_mac_if #(.ACC_W(12)) busA ();
    vedic4_mac_if #(.ACC_W(8))  busB ();
    vedic4_mac_if #(.ACC_W(12)) busC ();

    vedic4_mac #(.N_TERMS(4), .ACC_W(12)) dutA (.clk(clk), .rst(rst), .bus(busA));
    vedic4_mac #(.N_TERMS(2), .ACC_W(8))  dutB (.clk(clk), .rst(rst), .bus(busB));
    vedic4_mac #(.N_TERMS(1), .ACC_W(12)) dutC (.clk(clk), .rst(rst), .bus(busC));

    always #5 clk = ~clk;

    assign busA.in_valid  = tbValid && (sel == 0);
    assign busB.in_valid  = tbValid && (sel == 1);
    assign busC.in_valid  = tbValid && (sel == 2);
    assign busA.in_a      = inA;
    assign busB.in_a      = inA;
    assign busC.in_a      = inA;
    assign busA.in_b      = inB;
    assign busB.in_b      = inB;
    assign busC.in_b      = inB;
    assign busA.out_ready = outReady;
    assign busB.out_ready = outReady;
    assign busC.out_ready = outReady;

    always_comb begin
        tbReady    = busA.in_ready;
        tbOutValid = busA.out_valid;
        tbSum      = busA.out_sum;
        tbOvf      = busA.out_ovf;
        if (sel == 1) begin
            tbReady    = busB.in_ready;
            tbOutValid = busB.out_valid;
            tbSum      = 12'(busB.out_sum);
            tbOvf      = busB.out_ovf;
        end else if (sel == 2) begin
            tbReady    = busC.in_ready;
            tbOutValid = busC.out_valid;
            tbSum      = busC.out_sum;
            tbOvf      = busC.out_ovf;
        end
    end

    task automatic checkOutput(input string name, input int act, input int exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic reportTimeout(input string name);
        compared++;
        mismatched++;
        $display("[TB] FAIL %s: timed out waiting for DUT (t=%0t)", name, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offers one pair and returns just after the edge that accepted it.
    task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b);
        bit accepted = 0;
        inA     = a;
        inB     = b;
        tbValid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (tbReady) begin
                tick();
                accepted = 1;
                break;
            end
            tick();
        end
        tbValid = 1'b0;
        if (!accepted) reportTimeout("acceptPair");
    endtask

    task automatic waitEmpty(input string name);
        bit done = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (expQ.size() == 0) begin
                done = 1;
                break;
            end
        end
        if (!done) begin
            reportTimeout(name);
            expQ.delete();
        end
    endtask

    // Releases the pending result and confirms the block is ready for a new group.
    task automatic finishGroup(input int sum, input logic ovf);
        exp_t e;
        e.sum = sum;
        e.ovf = ovf;
        expQ.push_back(e);
        outReady = 1'b1;
        waitEmpty("resultDrain");
        outReady = 1'b0;
        @(negedge clk);
        checkOutput("validAfterTake", int'(tbOutValid), 0);
        checkOutput("readyAfterTake", int'(tbReady), 1);
        tick();
    endtask

    task automatic runGroup(input group_t g);
        bit seen = 0;
        sel      = g.sel;
        outReady = 1'b0;
        for (int t = 0; t < g.nTerms; t++) begin
            if (t > 0 && g.gap > 0) repeat ($urandom_range(1, g.gap)) tick();
            applyStimulus(g.aVec[4*t +: 4], g.bVec[4*t +: 4]);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (tbOutValid) begin
                seen = 1;
                break;
            end
            tick();
        end
        if (!seen) reportTimeout("waitOutValid");
        for (int h = 0; h < g.hold; h++) begin
            tick();
            @(negedge clk);
            checkOutput("holdSum", int'(tbSum), g.expSum);
            checkOutput("holdReady", int'(tbReady), 0);
            checkOutput("holdValid", int'(tbOutValid), 1);
        end
        tick();
        finishGroup(g.expSum, g.expOvf);
    endtask

    // Scoreboard: every completed output handshake must match the oldest expected result.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (tbOutValid && outReady) begin
                if (expQ.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL unexpectedResult: got sum %0d with no result pending", tbSum);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("resultSum", int'(tbSum), e.sum);
                    checkOutput("resultOvf", int'(tbOvf), int'(e.ovf));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        group_t vecs[6];
        vecs[0] = '{0, 4, 16'h7A10, 16'h739D, 3, 5, 88, 1'b0};
        vecs[1] = '{0, 4, 16'h2222, 16'h3333, 0, 0, 24, 1'b0};
`ifdef VEDIC4_MAC_SAT_EN
        vecs[2] = '{1, 2, 16'h00FF, 16'h00FF, 0, 2, 255, 1'b1};
`else
        vecs[2] = '{1, 2, 16'h00FF, 16'h00FF, 0, 2, 194, 1'b1};
`endif
        vecs[3] = '{1, 2, 16'h0053, 16'h0064, 1, 0, 42, 1'b0};
        vecs[4] = '{0, 4, 16'h9431, 16'h2451, 2, 1, 50, 1'b0};
        vecs[5] = '{2, 1, 16'h000C, 16'h000B, 0, 0, 132, 1'b0};

        rst      = 1'b1;
        tbValid  = 1'b0;
        inA      = '0;
        inB      = '0;
        outReady = 1'b0;
        sel      = 0;

        repeat (2) tick();
        @(negedge clk);
        checkOutput("rstValid", int'(tbOutValid), 0);
        checkOutput("rstSum", int'(tbSum), 0);
        checkOutput("rstOvf", int'(tbOvf), 0);
        checkOutput("rstReady", int'(tbReady), 0);
        checkOutput("rstReadyC", int'(busC.in_ready), 0);
        rst = 1'b0;
        tick();
        @(negedge clk);
        checkOutput("readyAfterRst", int'(tbReady), 1);
        checkOutput("readyAfterRstB", int'(busB.in_ready), 1);
        tick();

        // Back-to-back (15,15)x4: DRAIN cycle, then result held while out_ready is low.
        sel = 0;
        repeat (4) applyStimulus(4'd15, 4'd15);
        @(negedge clk);
        checkOutput("drainValid", int'(tbOutValid), 0);
        checkOutput("drainReady", int'(tbReady), 0);
        tick();
        @(negedge clk);
        checkOutput("holdValid900", int'(tbOutValid), 1);
        checkOutput("holdSum900", int'(tbSum), 900);
        checkOutput("holdReady900", int'(tbReady), 0);
        tick();
        finishGroup(900, 1'b0);

        for (int v = 0; v < 6; v++) runGroup(vecs[v]);

        // Reset after two accepted terms discards the partial group.
        sel = 0;
        repeat (2) applyStimulus(4'd15, 4'd15);
        @(negedge clk);
        checkOutput("partialSum", int'(tbSum), 225);
        rst = 1'b1;
        tick();
        @(negedge clk);
        checkOutput("midRstValid", int'(tbOutValid), 0);
        checkOutput("midRstSum", int'(tbSum), 0);
        checkOutput("midRstOvf", int'(tbOvf), 0);
        checkOutput("midRstReady", int'(tbReady), 0);
        rst = 1'b0;
        tick();
        @(negedge clk);
        checkOutput("readyAfterMidRst", int'(tbReady), 1);
        tick();
        runGroup(vecs[1]);

        // N_TERMS=1 with in_valid held high through DRAIN and HOLD, then taken with the result.
        sel = 2;
        outReady = 1'b0;
        applyStimulus(4'd12, 4'd11);
        tbValid = 1'b1;
        inA     = 4'd5;
        inB     = 4'd5;
        @(negedge clk);
        checkOutput("n1DrainValid", int'(tbOutValid), 0);
        checkOutput("n1DrainReady", int'(tbReady), 0);
        tick();
        @(negedge clk);
        checkOutput("n1HoldValid", int'(tbOutValid), 1);
        checkOutput("n1HoldSum", int'(tbSum), 132);
        tick();
        @(negedge clk);
        checkOutput("n1HoldSumStable", int'(tbSum), 132);
        checkOutput("n1HoldReady", int'(tbReady), 0);
        tick();
        expQ.push_back('{132, 1'b0});
        expQ.push_back('{25, 1'b0});
        outReady = 1'b1;
        tick();
        @(negedge clk);
        checkOutput("n1ValidAfterTake", int'(tbOutValid), 0);
        checkOutput("n1ReadyAfterTake", int'(tbReady), 1);
        tick();
        tbValid = 1'b0;
        waitEmpty("n1SecondResult");
        outReady = 1'b0;
        repeat (3) tick();

        checkOutput("queueEmpty", expQ.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
